// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin arbiter (arb_rrb).
//   arb_state_t : arbiter FSM encoding (IDLE = free to select, LOCK = packet in flight)
//   idx_next()  : modulo-WIDTH increment of a requester index. The wrap is an
//                 explicit compare, so non-power-of-2 WIDTH wraps correctly.
package arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  function automatic int unsigned idx_next(input int unsigned idx, input int unsigned width);
    return (idx == width - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/arb_rrb_psel.sv
// Priority-select multiplexer: finds the lowest set bit of req and muxes the
// matching payload.
//   req  : request vector
//   din  : per-requester payload
//   vld  : any request present
//   idx  : index of the lowest set bit (0 when req is empty)
//   dout : din[idx]
// IMPLEMENTATION 0 is a flat linear scan. Any other value scans in groups of
// SPLIT bits: the lowest non-empty group first, then the lowest bit inside it.
module arb_rrb_psel
  import arb_pkg::*;
#(
  parameter type DAT_T          = logic [8-1:0],
  parameter int  WIDTH          = 4,
  parameter int  SPLIT          = 2,
  parameter int  IMPLEMENTATION = 0,
  parameter int  IDX_W          = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] req,
  input  DAT_T             din [WIDTH],
  output logic             vld,
  output logic [IDX_W-1:0] idx,
  output DAT_T             dout
);

  assign vld  = |req;
  assign dout = din[idx];

  if (IMPLEMENTATION == 0) begin : g_flat
    always_comb begin
      idx = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (req[i]) idx = IDX_W'(i);
      end
    end
  end else begin : g_group
    localparam int NGRP = (WIDTH + SPLIT - 1) / SPLIT;
    int   g_sel;
    logic g_any;

    always_comb begin
      g_sel = 0;
      g_any = 1'b0;
      idx   = '0;
      for (int g = NGRP - 1; g >= 0; g--) begin
        g_any = 1'b0;
        for (int b = 0; b < SPLIT; b++) begin
          if (g * SPLIT + b < WIDTH) g_any = g_any | req[g * SPLIT + b];
        end
        if (g_any) g_sel = g;
      end
      for (int b = SPLIT - 1; b >= 0; b--) begin
        if ((g_sel * SPLIT + b < WIDTH) && req[g_sel * SPLIT + b]) idx = IDX_W'(g_sel * SPLIT + b);
      end
    end
  end

endmodule

// File: rtl/arb_rrb_slice.sv
// Full-throughput registered output slice with a one-entry skid buffer.
//   in_*  : upstream channel (from the arbiter); in_rdy is a registered signal
//   out_* : registered downstream channel, one cycle behind the input
// The skid entry catches the beat accepted in the cycle the downstream stalls,
// so in_rdy never depends combinationally on out_rdy.
module arb_rrb_slice
  import arb_pkg::*;
#(
  parameter type DAT_T = logic [8-1:0],
  parameter int  IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  DAT_T             in_dat,
  input  logic             in_lst,
  input  logic [IDX_W-1:0] in_idx,
  output logic             in_rdy,
  output logic             out_vld,
  output DAT_T             out_dat,
  output logic             out_lst,
  output logic [IDX_W-1:0] out_idx,
  input  logic             out_rdy
);

  logic             vld_p1, skd_vld;
  DAT_T             dat_p1, skd_dat;
  logic             lst_p1, skd_lst;
  logic [IDX_W-1:0] idx_p1, skd_idx;
  logic             load;

  assign in_rdy = ~skd_vld;
  // Output register may take a new beat when it is empty or being drained.
  assign load   = out_rdy | ~vld_p1;

  // ---- stage p1: output register / skid entry (control) ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      skd_vld <= 1'b0;
    end else if (load) begin
      vld_p1  <= skd_vld | in_vld;
      skd_vld <= 1'b0;
    end else if (in_vld & ~skd_vld) begin
      skd_vld <= 1'b1;
    end
  end

  // ---- stage p1: output register / skid entry (data) ----
  always_ff @(posedge clk) begin
    if (load) begin
      if (skd_vld) begin
        dat_p1 <= skd_dat;
        lst_p1 <= skd_lst;
        idx_p1 <= skd_idx;
      end else begin
        dat_p1 <= in_dat;
        lst_p1 <= in_lst;
        idx_p1 <= in_idx;
      end
    end else if (in_vld & ~skd_vld) begin
      skd_dat <= in_dat;
      skd_lst <= in_lst;
      skd_idx <= in_idx;
    end
  end

  assign out_vld = vld_p1;
  assign out_dat = dat_p1;
  assign out_lst = lst_p1;
  assign out_idx = idx_p1;

endmodule

// File: rtl/arb_rrb.sv
// Round-robin arbiter with integrated data multiplexer. WIDTH requesters share
// one downstream valid/ready channel; multi-beat packets hold the grant until
// the beat flagged last is accepted.
//   clk, rst           : clock, synchronous active-high reset
//   req_vld/lst/dat    : per-requester valid, last-beat flag, payload
//   req_rdy            : per-requester ready (one-hot on the selected requester)
//   out_vld/lst/dat    : downstream valid, last-beat flag, payload
//   out_idx            : index of the requester being forwarded
//   out_rdy            : downstream ready
// Optional feature: define ARB_RRB_OUT_REG_EN to insert a registered output
// slice (1-cycle latency, out_rdy decoupled from req_rdy). Default build is a
// purely combinational req_* -> out_* path.
module arb_rrb
  import arb_pkg::*;
#(
  parameter type DAT_T          = logic [8-1:0],
  parameter int  WIDTH          = 4,
  parameter int  SPLIT          = 2,
  parameter int  IMPLEMENTATION = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         req_vld,
  input  logic [WIDTH-1:0]         req_lst,
  input  DAT_T                     req_dat [WIDTH],
  output logic [WIDTH-1:0]         req_rdy,
  output logic                     out_vld,
  output logic                     out_lst,
  output DAT_T                     out_dat,
  output logic [$clog2(WIDTH)-1:0] out_idx,
  input  logic                     out_rdy
);

  localparam int IDX_W = $clog2(WIDTH);

  arb_state_t       state, state_nxt;
  logic [IDX_W-1:0] ptr, ptr_nxt;
  logic [IDX_W-1:0] gnt, gnt_nxt;

  logic [WIDTH-1:0] req_msk;
  logic             m_vld, u_vld;
  logic [IDX_W-1:0] m_idx, u_idx;
  DAT_T             m_dat, u_dat;

  logic             arb_vld, arb_lst, arb_rdy, xfer;
  logic [IDX_W-1:0] sel_idx;
  DAT_T             arb_dat;

  // Requests at or above the pointer get first pick; this realises the
  // rotating priority without a barrel shifter.
  for (genvar i = 0; i < WIDTH; i++) begin : g_msk
    assign req_msk[i] = req_vld[i] & (IDX_W'(i) >= ptr);
  end

  arb_rrb_psel #(
    .DAT_T(DAT_T), .WIDTH(WIDTH), .SPLIT(SPLIT), .IMPLEMENTATION(IMPLEMENTATION), .IDX_W(IDX_W)
  ) u_psel_msk (
    .req(req_msk), .din(req_dat), .vld(m_vld), .idx(m_idx), .dout(m_dat)
  );

  arb_rrb_psel #(
    .DAT_T(DAT_T), .WIDTH(WIDTH), .SPLIT(SPLIT), .IMPLEMENTATION(IMPLEMENTATION), .IDX_W(IDX_W)
  ) u_psel_all (
    .req(req_vld), .din(req_dat), .vld(u_vld), .idx(u_idx), .dout(u_dat)
  );

  // Selection: rotating priority in IDLE, forced to the locked owner in LOCK.
  always_comb begin
    sel_idx = m_vld ? m_idx : u_idx;
    arb_dat = m_vld ? m_dat : u_dat;
    arb_vld = u_vld;
    if (state == LOCK) begin
      sel_idx = gnt;
      arb_dat = req_dat[gnt];
      arb_vld = req_vld[gnt];
    end
    arb_lst = req_lst[sel_idx];
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_rdy
    assign req_rdy[i] = arb_rdy & arb_vld & (sel_idx == IDX_W'(i));
  end

  assign xfer = arb_vld & arb_rdy;

  // Pointer moves only on an accepted last beat; a non-last beat in IDLE
  // locks the grant to the current selection.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    gnt_nxt   = gnt;
    if (xfer) begin
      if (arb_lst) begin
        state_nxt = IDLE;
        ptr_nxt   = IDX_W'(idx_next(32'(sel_idx), WIDTH));
      end else if (state == IDLE) begin
        state_nxt = LOCK;
        gnt_nxt   = sel_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      gnt   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      gnt   <= gnt_nxt;
    end
  end

`ifdef ARB_RRB_OUT_REG_EN
  arb_rrb_slice #(
    .DAT_T(DAT_T), .IDX_W(IDX_W)
  ) u_slice (
    .clk    (clk),
    .rst    (rst),
    .in_vld (arb_vld),
    .in_dat (arb_dat),
    .in_lst (arb_lst),
    .in_idx (sel_idx),
    .in_rdy (arb_rdy),
    .out_vld(out_vld),
    .out_dat(out_dat),
    .out_lst(out_lst),
    .out_idx(out_idx),
    .out_rdy(out_rdy)
  );
`else
  assign arb_rdy = out_rdy;
  assign out_vld = arb_vld;
  assign out_dat = arb_dat;
  assign out_lst = arb_lst;
  assign out_idx = sel_idx;
`endif

endmodule

// File: tb/tb_arb_rrb.sv
// Testbench for arb_rrb: directed scenarios followed by randomized traffic,
// checked against a behavioural round-robin model (circular scan from the
// pointer, owner index for locked packets, queue for the optional output slice).
module tb_arb_rrb;

  localparam int WIDTH = 4;
  localparam int IW    = $clog2(WIDTH);
  typedef logic [7:0] dat_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] req_vld, req_lst, req_rdy;
  dat_t             req_dat [WIDTH];
  logic             out_vld, out_lst, out_rdy;
  dat_t             out_dat;
  logic [IW-1:0]    out_idx;

  arb_rrb #(
    .DAT_T(dat_t), .WIDTH(WIDTH), .SPLIT(2), .IMPLEMENTATION(0)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req_vld(req_vld),
    .req_lst(req_lst),
    .req_dat(req_dat),
    .req_rdy(req_rdy),
    .out_vld(out_vld),
    .out_lst(out_lst),
    .out_dat(out_dat),
    .out_idx(out_idx),
    .out_rdy(out_rdy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s act=%0h want=%0h t=%0t", tag, act, want, $time);
    end
  endtask

  // Reference model state
  int own = -1;   // requester holding a packet lock, -1 when free
  int ptr = 0;    // first requester to consider in the circular scan
  int sel;
  bit svld;

  typedef struct packed {
    logic [7:0]    d;
    logic          l;
    logic [IW-1:0] i;
  } beat_t;
  beat_t q[$];

  function automatic void pick();
    int i;
    if (own >= 0) begin
      sel  = own;
      svld = req_vld[own];
    end else begin
      sel  = 0;
      svld = 1'b0;
      for (int k = 0; k < WIDTH; k++) begin
        i = (ptr + k) % WIDTH;
        if (!svld && req_vld[i]) begin
          sel  = i;
          svld = 1'b1;
        end
      end
    end
  endfunction

  // One clock cycle: entered and left at posedge+1. exp_idx >= 0 adds a
  // scenario-specific index check in the combinational build.
  task automatic cyc(input logic [WIDTH-1:0] v, input logic [WIDTH-1:0] l, input logic r,
                     input int exp_idx);
    bit   ardy, xfer;
    req_vld = v;
    req_lst = l;
    out_rdy = r;
    for (int i = 0; i < WIDTH; i++) req_dat[i] = 8'($urandom);
    #4;
    pick();
`ifdef ARB_RRB_OUT_REG_EN
    ardy = (q.size() < 2);
    check("out_vld", {31'd0, out_vld}, {31'd0, q.size() > 0});
    if (q.size() > 0) begin
      check("out_dat", {24'd0, out_dat}, {24'd0, q[0].d});
      check("out_lst", {31'd0, out_lst}, {31'd0, q[0].l});
      check("out_idx", {30'd0, out_idx}, {30'd0, q[0].i});
    end
`else
    ardy = r;
    check("out_vld", {31'd0, out_vld}, {31'd0, svld});
    check("out_idx", {30'd0, out_idx}, 32'(sel));
    check("out_dat", {24'd0, out_dat}, {24'd0, req_dat[sel]});
    check("out_lst", {31'd0, out_lst}, {31'd0, req_lst[sel]});
    if (exp_idx >= 0) check("plan_idx", {30'd0, out_idx}, 32'(exp_idx));
`endif
    check("req_rdy", {28'd0, req_rdy}, (svld && ardy) ? (32'd1 << sel) : 32'd0);
    xfer = svld && ardy;
`ifdef ARB_RRB_OUT_REG_EN
    if (q.size() > 0 && r) void'(q.pop_front());
    if (xfer) q.push_back('{d: req_dat[sel], l: req_lst[sel], i: IW'(sel)});
`endif
    if (xfer) begin
      if (req_lst[sel]) begin
        own = -1;
        ptr = (sel + 1) % WIDTH;
      end else begin
        own = sel;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_rst(input logic [WIDTH-1:0] v);
    rst     = 1'b1;
    req_vld = v;
    req_lst = '0;
    out_rdy = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    own = -1;
    ptr = 0;
    q.delete();
  endtask

  initial begin
    rst     = 1'b1;
    req_vld = '0;
    req_lst = '0;
    out_rdy = 1'b0;
    for (int i = 0; i < WIDTH; i++) req_dat[i] = dat_t'(i);
    repeat (2) @(posedge clk);
    #1;
    do_rst('0);

    // Idle: nothing requested, pointer must stay at 0
    for (int k = 0; k < 10; k++) cyc(4'b0000, 4'b0000, 1'b1, 0);

    // Fairness: all request single-beat packets
    for (int k = 0; k < 8; k++) cyc(4'b1111, 4'b1111, 1'b1, k % 4);

    // Lock: requester 0 sends 3 beats while 1 waits
    cyc(4'b0011, 4'b0000, 1'b1, 0);
    cyc(4'b0011, 4'b0000, 1'b1, 0);
    cyc(4'b0011, 4'b0001, 1'b1, 0);
    cyc(4'b0011, 4'b0011, 1'b1, 1);

    // Backpressure and wrap: grant 2 -> ptr 3, then stall 5 cycles
    cyc(4'b0100, 4'b0100, 1'b1, 2);
    for (int k = 0; k < 5; k++) cyc(4'b1001, 4'b1001, 1'b0, 3);
    cyc(4'b1001, 4'b1001, 1'b1, 3);
    cyc(4'b1001, 4'b1001, 1'b1, 0);

    // Owner drops valid mid-packet: lock held, others not served
    cyc(4'b0010, 4'b0000, 1'b1, 1);
    cyc(4'b1100, 4'b0000, 1'b1, 1);
    cyc(4'b1110, 4'b0010, 1'b1, 1);

    // Reset mid-packet: requester 2 locked after beat 1
    cyc(4'b0100, 4'b0000, 1'b1, -1);
    cyc(4'b0100, 4'b0000, 1'b1, 2);
    do_rst(4'b0110);
    cyc(4'b0110, 4'b0110, 1'b1, 1);

    // Randomized traffic with occasional resets
    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_rst(WIDTH'($urandom));
      end else begin
        cyc(WIDTH'($urandom), WIDTH'($urandom), ($urandom_range(0, 3) != 0), -1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
